// File: rtl/snes_event_queue_if.sv
// snes_event_queue_if: controller read port and CPU event-queue signals of snes_event_queue.
interface snes_event_queue_if;
    logic        snes_read_enable;
    logic [1:0]  snes_address;
    logic [11:0] snes_read_data;
    logic        evt_pop;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic [4:0]  evt_count;
    logic        overflow;
    logic        overflow_clr;
    logic [11:0] held0;
    logic [11:0] held1;
    modport master (
        output snes_read_enable, snes_address, evt_valid, evt_data, evt_count, overflow, held0, held1,
        input  snes_read_data, evt_pop, overflow_clr
    );
    modport slave (
        input  snes_read_enable, snes_address, evt_valid, evt_data, evt_count, overflow, held0, held1,
        output snes_read_data, evt_pop, overflow_clr
    );
endinterface

// File: rtl/snes_event_queue.sv
// snes_event_queue: periodic SNES pad poller that diffs button words into an FWFT event FIFO.
// Define SNES_RELEASE_EVT_EN to queue release events as well as presses.
module snes_event_queue #(
    parameter int POLL_CYCLES = 208333,
    parameter int SCAN_WAIT   = 64,
    parameter int FIFO_DEPTH  = 8
) (
    input logic clk,
    input logic rst,
    snes_event_queue_if.master eq
);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam int WW = $clog2(SCAN_WAIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_TRIG, S_WAIT, S_RD0, S_CAP0, S_RD1, S_CAP1, S_SCAN, S_COMMIT
    } state_t;

    state_t      state;
    logic [PW-1:0] poll;
    logic [WW-1:0] wcnt;
    logic [4:0]  idx;
    logic [11:0] new0, new1, held0, held1;
    logic        re;
    logic [1:0]  addr;
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd, wr;
    logic [4:0]  count;
    logic        ovf;

    logic        pad, nb, ob, push, pop, push_ok, drop;
    logic [3:0]  b;
    logic [15:0] evt;

    assign pad = idx >= 5'd12;
    assign b   = pad ? 4'(idx - 5'd12) : idx[3:0];
    assign nb  = pad ? new1[b] : new0[b];
    assign ob  = pad ? held1[b] : held0[b];
    assign evt = {pad, nb, 10'b0, b};
`ifdef SNES_RELEASE_EVT_EN
    assign push = (state == S_SCAN) && (nb != ob);
`else
    assign push = (state == S_SCAN) && nb && !ob;
`endif
    assign pop     = eq.evt_pop && (count != 5'd0);
    // a full FIFO still accepts a push when the head leaves in the same clock
    assign push_ok = push && ((count != 5'(FIFO_DEPTH)) || pop);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            poll  <= '0;
            wcnt  <= '0;
            idx   <= '0;
            re    <= 1'b0;
            addr  <= 2'b00;
            new0  <= '0;
            new1  <= '0;
            held0 <= '0;
            held1 <= '0;
        end else begin
            poll <= (poll == PW'(POLL_CYCLES - 1)) ? poll : poll + 1'b1;
            re   <= 1'b0;
            addr <= 2'b00;
            case (state)
                S_IDLE: if (poll == PW'(POLL_CYCLES - 1)) begin
                    poll  <= '0;
                    state <= S_TRIG;
                    re    <= 1'b1;
                    addr  <= 2'b10;
                end
                S_TRIG: begin
                    state <= S_WAIT;
                    wcnt  <= '0;
                end
                S_WAIT: if (wcnt == WW'(SCAN_WAIT - 1)) begin
                    state <= S_RD0;
                    re    <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                S_RD0: state <= S_CAP0;
                S_CAP0: begin
                    new0  <= eq.snes_read_data;
                    state <= S_RD1;
                    re    <= 1'b1;
                    addr  <= 2'b01;
                end
                S_RD1: state <= S_CAP1;
                S_CAP1: begin
                    new1  <= eq.snes_read_data;
                    idx   <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: if (idx == 5'd23) state <= S_COMMIT; else idx <= idx + 1'b1;
                S_COMMIT: begin
                    held0 <= new0;
                    held1 <= new1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr] <= evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + 5'(push_ok) - 5'(pop);
            ovf   <= drop | (ovf & ~eq.overflow_clr);
        end
    end

    assign eq.snes_read_enable = re;
    assign eq.snes_address     = addr;
    assign eq.evt_valid        = count != 5'd0;
    assign eq.evt_data         = (count != 5'd0) ? mem[rd] : 16'h0000;
    assign eq.evt_count        = count;
    assign eq.overflow         = ovf;
    assign eq.held0            = held0;
    assign eq.held1            = held1;
endmodule

// File: tb/tb_snes_event_queue.sv
// tb_snes_event_queue: randomized bench for snes_event_queue against a scan-schedule/queue model.
module tb_snes_event_queue;
    localparam int P  = 200;
    localparam int SW = 64;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snes_event_queue_if eq();
    snes_event_queue #(.POLL_CYCLES(P), .SCAN_WAIT(SW), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .eq(eq));

    logic [11:0] pad0 = 12'h000;
    logic [11:0] pad1 = 12'h000;
    int n_chk = 0;
    int n_fail = 0;

    // controller interface stand-in: word registered one clock after a pad read
    always @(posedge clk or posedge rst) begin
        if (rst) eq.snes_read_data <= 12'h000;
        else if (eq.snes_read_enable && eq.snes_address != 2'b10)
            eq.snes_read_data <= eq.snes_address[0] ? pad1 : pad0;
    end

    // model: edges since reset, scan schedule offsets from each trigger, event queue
    int m_e, m_o, m_i, m_b;
    logic [15:0] mq[$];
    logic [15:0] m_ev;
    logic m_ovf, m_push, m_drop, m_nb, m_ob, m_pad;
    logic [11:0] m_h0, m_h1, m_n0, m_n1;

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0; mq.delete(); m_ovf = 0;
            m_h0 = 0; m_h1 = 0; m_n0 = 0; m_n1 = 0;
        end else begin
            m_e++;
            m_o = (m_e >= P) ? m_e % P : -1;
            if (m_o == SW + 2) m_n0 = pad0;
            if (m_o == SW + 4) m_n1 = pad1;
            m_push = 0;
            m_drop = 0;
            if (m_o >= SW + 6 && m_o <= SW + 29) begin
                m_i = m_o - SW - 6;
                m_pad = m_i >= 12;
                m_b = m_i % 12;
                m_nb = m_pad ? m_n1[m_b] : m_n0[m_b];
                m_ob = m_pad ? m_h1[m_b] : m_h0[m_b];
`ifdef SNES_RELEASE_EVT_EN
                m_push = m_nb != m_ob;
`else
                m_push = m_nb && !m_ob;
`endif
                m_ev = {m_pad, m_nb, 10'b0, 4'(m_b)};
            end
            if (eq.evt_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < D) mq.push_back(m_ev);
                else m_drop = 1;
            end
            m_ovf = m_drop ? 1'b1 : (eq.overflow_clr ? 1'b0 : m_ovf);
            if (m_o == SW + 30) begin
                m_h0 = m_n0;
                m_h1 = m_n1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
        end
    endtask

    int c_o;
    always @(negedge clk) begin
        c_o = (m_e >= P) ? m_e % P : -1;
        chk("evt_valid", 32'(eq.evt_valid), 32'(mq.size() != 0));
        chk("evt_data", 32'(eq.evt_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk("evt_count", 32'(eq.evt_count), 32'(mq.size()));
        chk("overflow", 32'(eq.overflow), 32'(m_ovf));
        chk("held0", 32'(eq.held0), 32'(m_h0));
        chk("held1", 32'(eq.held1), 32'(m_h1));
        chk("read_enable", 32'(eq.snes_read_enable), 32'(c_o == 0 || c_o == SW + 1 || c_o == SW + 3));
        chk("address", 32'(eq.snes_address), c_o == 0 ? 32'd2 : (c_o == SW + 3 ? 32'd1 : 32'd0));
    end

    task automatic run_to(input int t);
        while (m_e < t) @(negedge clk);
    endtask

    task automatic pop_lit(input logic [15:0] exp);
        chk("head literal", 32'(eq.evt_data), 32'(exp));
        eq.evt_pop = 1'b1;
        @(negedge clk);
        eq.evt_pop = 1'b0;
    endtask

    initial begin
        eq.evt_pop = 1'b0;
        eq.overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset count", 32'(eq.evt_count), 0);
        chk("reset valid", 32'(eq.evt_valid), 0);
        run_to(P - 1);
        chk("pre-trigger re", 32'(eq.snes_read_enable), 0);
        run_to(P);
        chk("trigger re", 32'(eq.snes_read_enable), 1);
        chk("trigger addr", 32'(eq.snes_address), 2);
        run_to(P + SW + 31);
        chk("idle scan count", 32'(eq.evt_count), 0);
        chk("idle scan held0", 32'(eq.held0), 0);

        pad0 = 12'h005; pad1 = 12'h800;
        run_to(2 * P + SW + 5);
        chk("pre-event valid", 32'(eq.evt_valid), 0);
        run_to(2 * P + SW + 6);
        chk("first event valid", 32'(eq.evt_valid), 1);
        run_to(2 * P + SW + 30);
        chk("scan1 count", 32'(eq.evt_count), 3);
        chk("scan1 held0", 32'(eq.held0), 32'h005);
        chk("scan1 held1", 32'(eq.held1), 32'h800);
        pop_lit(16'h4000);
        pop_lit(16'h4002);
        pop_lit(16'hC00B);
        chk("drained count", 32'(eq.evt_count), 0);

        pad0 = 12'h004;
        run_to(3 * P + SW + 30);
`ifdef SNES_RELEASE_EVT_EN
        chk("release count", 32'(eq.evt_count), 1);
        pop_lit(16'h0000);
`else
        chk("release silent count", 32'(eq.evt_count), 0);
`endif
        chk("release held0", 32'(eq.held0), 32'h004);

        pad0 = 12'hFFF; pad1 = 12'h801;
        run_to(4 * P + SW + 30);
        chk("ovf count", 32'(eq.evt_count), 8);
        chk("ovf flag", 32'(eq.overflow), 1);
        chk("ovf head", 32'(eq.evt_data), 32'h4000);
        eq.overflow_clr = 1'b1;
        @(negedge clk);
        eq.overflow_clr = 1'b0;
        chk("ovf cleared", 32'(eq.overflow), 0);
        chk("still full", 32'(eq.evt_count), 8);

        pad0 = 12'h000; pad1 = 12'hFFF;
        run_to(5 * P + SW + 5);
        eq.evt_pop = 1'b1;
        run_to(5 * P + SW + 29);
        eq.evt_pop = 1'b0;
        chk("full push+pop no ovf", 32'(eq.overflow), 0);
        for (int j = 0; j < 20 && eq.evt_valid; j++) begin
            eq.evt_pop = 1'b1;
            @(negedge clk);
        end
        eq.evt_pop = 1'b0;

        for (int s = 0; s < 4; s++) begin
            run_to((6 + s) * P + 150);
            pad0 = 12'($urandom);
            pad1 = 12'($urandom);
            while (m_e < (7 + s) * P + 150) begin
                eq.evt_pop = ($urandom % 3) == 0;
                eq.overflow_clr = ($urandom % 17) == 0;
                @(negedge clk);
            end
        end
        eq.evt_pop = 1'b0;
        eq.overflow_clr = 1'b0;

        run_to(11 * P + 30);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst valid", 32'(eq.evt_valid), 0);
        chk("rst count", 32'(eq.evt_count), 0);
        chk("rst data", 32'(eq.evt_data), 0);
        chk("rst held0", 32'(eq.held0), 0);
        chk("rst held1", 32'(eq.held1), 0);
        chk("rst overflow", 32'(eq.overflow), 0);
        chk("rst re", 32'(eq.snes_read_enable), 0);
        rst = 1'b0;
        run_to(P - 1);
        chk("post-rst pre-trigger", 32'(eq.snes_read_enable), 0);
        run_to(P);
        chk("post-rst trigger re", 32'(eq.snes_read_enable), 1);
        chk("post-rst trigger addr", 32'(eq.snes_address), 2);
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/snes_event_queue.md
# snes_event_queue

Autonomous poller and event queue downstream of the SNES controller interface. It periodically triggers a controller scan, reads both 12-bit button words back through the interface's read port, and diffs them against the previously held state. Every button change is pushed as a 16-bit event into a first-word-fall-through FIFO for the CPU, so software never has to poll the pads or time the shift sequence.

## Interface
- POLL_CYCLES, 208333, clocks between scan triggers (60 Hz at 12.5 MHz); minimum 128
- SCAN_WAIT, 64, clocks from trigger to first readback; must cover the interface's full shift sequence (about 56 clocks)
- FIFO_DEPTH, 8, event entries; power of two, 2..16
- clk  in  1  system clock, 12.5 MHz
- rst  in  1  asynchronous, active-high reset
- snes_read_enable  out  1  to the interface's read_enable
- snes_address  out  2  to the interface's address; 2'b10 triggers a scan, 2'b00/2'b01 select the pad to read
- snes_read_data  in  12  button word from the interface, registered one clock after read_enable
- evt_pop  in  1  consume the head event
- evt_valid  out  1  FIFO not empty
- evt_data  out  16  head event: [15] pad, [14] 1=press / 0=release, [13:4] zero, [3:0] button index 0..11
- evt_count  out  5  entries currently held
- overflow  out  1  sticky; set when an event is dropped
- overflow_clr  in  1  clears overflow
- held0, held1  out  12  last committed button state of each pad

## Operation
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - poll counter 0
  - FIFO empty
- Poll counter:
  - Increments every clock and saturates at POLL_CYCLES-1.
  - IDLE leaves for TRIG only when the counter is at terminal; the counter reloads to 0 on that transition.
- FSM states:
  - IDLE: waits for the poll counter.
  - TRIG (1 clk): read_enable=1, address=2'b10.
  - WAIT (SCAN_WAIT clks): outputs idle.
  - RD0 (1 clk): read_enable=1, address=0.
  - CAP0 (1 clk): new0 <= snes_read_data.
  - RD1 / CAP1: same for pad 1 into new1.
  - SCAN (24 clks): index i = 0..23. Pad = i/12, bit = i%12, comparing new vs held.
  - COMMIT (1 clk): held0 <= new0, held1 <= new1, then IDLE.
- SCAN push rule:
  - A changed bit pushes one event in that clock. The event is {pad, new_bit, 10'b0, bit}.
  - Events are ordered pad0 bit0 first through pad1 bit11 last.
- FIFO:
  - FWFT: evt_data is valid whenever evt_valid=1, and is 0 when empty.
  - Pop when empty is ignored.
  - Push when full drops the event and sets overflow.
  - Push and pop in the same clock while full succeeds: count is unchanged, nothing is dropped.
  - Push and pop in the same clock while empty: the pop is ignored and the push lands.
- held is always committed, even when events were dropped.
- overflow_clr and an overflow-setting drop in the same clock: overflow stays set.
- snes_address is 0 outside TRIG/RD0/RD1.

## Timing
- First trigger fires POLL_CYCLES clocks after rst deasserts.
- Trigger to COMMIT: 1 + SCAN_WAIT + 4 + 24 clocks.
- An event is visible on evt_valid/evt_data the clock after its SCAN cycle.
- evt_count updates the clock after push/pop.
- Pop takes effect on the clock edge where evt_pop=1; the next head is visible the following clock.
- rst asserted mid-scan:
  - Everything returns to reset values immediately.
  - The FIFO is emptied and held is cleared.
  - Any in-flight interface transaction is abandoned; the interface is reset by the same rst.

## Configuration
- SNES_RELEASE_EVT_EN defined: both press and release changes push events.
- SNES_RELEASE_EVT_EN undefined:
  - Only 0->1 transitions push events, so evt_data[14] is always 1.
  - Releases still update held silently.

## Test plan
- POLL_CYCLES=200, SCAN_WAIT=64, pad model returns 0 -> TRIG pulse (read_enable=1, address=2'b10) at clock 200 after reset; no events; held0=held1=0.
- Pad0 read_data=12'h005, pad1=12'h800 on first scan -> three events in order: 0x4000, 0x4002, 0xC00B; evt_count=3; held0=12'h005, held1=12'h800.
- Next scan, pad0=12'h004, with SNES_RELEASE_EVT_EN -> one event 0x0000. Without the macro -> no event, but held0=12'h004.
- FIFO_DEPTH=8, 12 presses in one scan, no pops -> evt_count=8, first 8 events retained, overflow=1. overflow_clr pulse -> overflow=0.
- FIFO full with evt_pop held high during SCAN pushes -> no drop, overflow stays 0, events stay in order.
- rst asserted during WAIT -> all outputs 0 next clock, FIFO empty. The next trigger occurs POLL_CYCLES clocks after rst release.
